// File: rtl/mist32e10fa_mem_pkg.sv
// Shared types and helpers for the arbiter-to-memory port bridge.
package mist32e10fa_mem_pkg;

    // Access size codes carried on the arbiter request; the byte mask is authoritative.
    localparam logic [1:0] ORDER_BYTE = 2'd0;
    localparam logic [1:0] ORDER_HALF = 2'd1;
    localparam logic [1:0] ORDER_WORD = 2'd2;

    // One memory-bus command as held in the command FIFO.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [1:0]  order;   // kept for debug visibility only
    } mem_cmd_t;

    localparam int unsigned MEM_CMD_W = $bits(mem_cmd_t);

    // Translate a 32-bit arbiter beat into a 64-bit bus command.
    function automatic mem_cmd_t build_cmd(
        input logic        rw,
        input logic [31:0] addr,
        input logic [3:0]  mask,
        input logic [31:0] data,
        input logic [1:0]  order
    );
        mem_cmd_t cmd;
        cmd.we    = rw;
        cmd.addr  = {addr[31:3], 3'b000};
        cmd.be    = addr[2] ? {mask, 4'h0} : {4'h0, mask};
        cmd.wdata = {data, data};
        cmd.order = order;
        return cmd;
    endfunction

endpackage

// File: rtl/memory_bridge_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
module memory_bridge_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntFull);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and count next-state; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Callers must never push into a full FIFO without a simultaneous pop.
    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o && !pop_i));

endmodule

// File: rtl/memory_port_bridge.sv
// Bridges the arbiter's 32-bit request stream onto a 64-bit command/response memory bus,
// reserving return-FIFO space per read so memory responses never need backpressure.
module memory_port_bridge
    import mist32e10fa_mem_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned RET_DEPTH = 8
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    // arbiter request side
    input  logic        iREQ_REQ,
    output logic        oREQ_LOCK,
    input  logic [1:0]  iREQ_ORDER,
    input  logic [3:0]  iREQ_MASK,
    input  logic        iREQ_RW,
    input  logic [31:0] iREQ_ADDR,
    input  logic [31:0] iREQ_DATA,
    // arbiter return side
    output logic        oRET_VALID,
    input  logic        iRET_BUSY,
    output logic [63:0] oRET_DATA,
    // memory command bus
    output logic        oMEM_CMD_VALID,
    input  logic        iMEM_CMD_READY,
    output logic        oMEM_CMD_WE,
    output logic [31:0] oMEM_CMD_ADDR,
    output logic [7:0]  oMEM_CMD_BE,
    output logic [63:0] oMEM_CMD_WDATA,
    // memory read response
    input  logic        iMEM_RD_VALID,
    input  logic [63:0] iMEM_RD_DATA,
    // status
    output logic        oERR
);

    localparam int unsigned CmdCntW = $clog2(CMD_DEPTH + 1);
    localparam int unsigned RetCntW = $clog2(RET_DEPTH + 1);
    localparam logic [RetCntW-1:0] RsvFull = RetCntW'(RET_DEPTH);

    // Command path
    mem_cmd_t           cmd_push_data;
    mem_cmd_t           cmd_head;
    logic               cmd_full;
    logic               cmd_empty;
    logic               cmd_pop;
    logic [CmdCntW-1:0] cmd_count_unused;

    // Return path
    logic [63:0]        ret_head;
    logic               ret_full_unused;
    logic               ret_empty;
    logic               ret_push;
    logic               ret_pop;
    logic [RetCntW-1:0] ret_count_unused;

    // Bookkeeping
    logic               lock;
    logic               req_accept;
    logic               rd_accept;
    logic               rd_issue;
    logic               rsp_unexpected;
    logic [RetCntW-1:0] rsv_q, rsv_d;   // reads accepted, not yet handed back to the arbiter
    logic [RetCntW-1:0] out_q, out_d;   // reads issued to memory, response not yet seen
    logic               err_q, err_d;

    // Lock depends only on registered state so the arbiter never sees a loop through iREQ_*.
    assign lock       = cmd_full || (rsv_q == RsvFull);
    assign req_accept = iREQ_REQ && !lock;
    assign rd_accept  = req_accept && !iREQ_RW;

    assign cmd_push_data = build_cmd(iREQ_RW, iREQ_ADDR, iREQ_MASK, iREQ_DATA, iREQ_ORDER);
    assign cmd_pop       = !cmd_empty && iMEM_CMD_READY;
    assign rd_issue      = cmd_pop && !cmd_head.we;

    assign ret_push       = iMEM_RD_VALID && (out_q != '0);
    assign rsp_unexpected = iMEM_RD_VALID && (out_q == '0);
    assign ret_pop        = !ret_empty && !iRET_BUSY;

    memory_bridge_fifo #(
        .WIDTH (MEM_CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (iCLOCK),
        .rst_i   (iRESET_SYNC),
        .push_i  (req_accept),
        .wdata_i (cmd_push_data),
        .pop_i   (cmd_pop),
        .rdata_o (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count_unused)
    );

    memory_bridge_fifo #(
        .WIDTH (64),
        .DEPTH (RET_DEPTH)
    ) u_ret_fifo (
        .clk_i   (iCLOCK),
        .rst_i   (iRESET_SYNC),
        .push_i  (ret_push),
        .wdata_i (iMEM_RD_DATA),
        .pop_i   (ret_pop),
        .rdata_o (ret_head),
        .full_o  (ret_full_unused),
        .empty_o (ret_empty),
        .count_o (ret_count_unused)
    );

    // Reservation, outstanding-read and sticky error next-state.
    always_comb begin
        rsv_d = rsv_q;
        out_d = out_q;
        err_d = err_q;
        unique case ({rd_accept, ret_pop})
            2'b10:   rsv_d = rsv_q + 1'b1;
            2'b01:   rsv_d = rsv_q - 1'b1;
            default: rsv_d = rsv_q;
        endcase
        unique case ({rd_issue, ret_push})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
        if (rsp_unexpected) begin
            err_d = 1'b1;
        end
    end

    // Counter and error registers.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            rsv_q <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            rsv_q <= rsv_d;
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign oREQ_LOCK      = lock;
    assign oMEM_CMD_VALID = !cmd_empty;
    assign oMEM_CMD_WE    = cmd_head.we;
    assign oMEM_CMD_ADDR  = cmd_head.addr;
    assign oMEM_CMD_BE    = cmd_head.be;
    assign oMEM_CMD_WDATA = cmd_head.wdata;
    assign oRET_VALID     = !ret_empty;
    assign oRET_DATA      = ret_head;
    assign oERR           = err_q;

    // Order is stored for debug, occupancy counts are informational only.
    logic unused_debug;
    assign unused_debug = ^{cmd_head.order, cmd_count_unused, ret_count_unused,
                            ret_full_unused};

endmodule

// File: tb/tb_memory_port_bridge.sv
// Directed self-checking bench for memory_port_bridge.
module tb_memory_port_bridge;
    import mist32e10fa_mem_pkg::*;

    logic        iCLOCK;
    logic        iRESET_SYNC;
    logic        iREQ_REQ;
    logic        oREQ_LOCK;
    logic [1:0]  iREQ_ORDER;
    logic [3:0]  iREQ_MASK;
    logic        iREQ_RW;
    logic [31:0] iREQ_ADDR;
    logic [31:0] iREQ_DATA;
    logic        oRET_VALID;
    logic        iRET_BUSY;
    logic [63:0] oRET_DATA;
    logic        oMEM_CMD_VALID;
    logic        iMEM_CMD_READY;
    logic        oMEM_CMD_WE;
    logic [31:0] oMEM_CMD_ADDR;
    logic [7:0]  oMEM_CMD_BE;
    logic [63:0] oMEM_CMD_WDATA;
    logic        iMEM_RD_VALID;
    logic [63:0] iMEM_RD_DATA;
    logic        oERR;

    int tests_run = 0;
    int tests_failed = 0;

    memory_port_bridge #(
        .CMD_DEPTH (4),
        .RET_DEPTH (8)
    ) dut (
        .iCLOCK         (iCLOCK),
        .iRESET_SYNC    (iRESET_SYNC),
        .iREQ_REQ       (iREQ_REQ),
        .oREQ_LOCK      (oREQ_LOCK),
        .iREQ_ORDER     (iREQ_ORDER),
        .iREQ_MASK      (iREQ_MASK),
        .iREQ_RW        (iREQ_RW),
        .iREQ_ADDR      (iREQ_ADDR),
        .iREQ_DATA      (iREQ_DATA),
        .oRET_VALID     (oRET_VALID),
        .iRET_BUSY      (iRET_BUSY),
        .oRET_DATA      (oRET_DATA),
        .oMEM_CMD_VALID (oMEM_CMD_VALID),
        .iMEM_CMD_READY (iMEM_CMD_READY),
        .oMEM_CMD_WE    (oMEM_CMD_WE),
        .oMEM_CMD_ADDR  (oMEM_CMD_ADDR),
        .oMEM_CMD_BE    (oMEM_CMD_BE),
        .oMEM_CMD_WDATA (oMEM_CMD_WDATA),
        .iMEM_RD_VALID  (iMEM_RD_VALID),
        .iMEM_RD_DATA   (iMEM_RD_DATA),
        .oERR           (oERR)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic set_req(input logic req, input logic rw, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] data);
        iREQ_REQ   = req;
        iREQ_RW    = rw;
        iREQ_ADDR  = addr;
        iREQ_MASK  = mask;
        iREQ_DATA  = data;
        iREQ_ORDER = ORDER_WORD;
    endtask

    task automatic test_reset();
        iRESET_SYNC = 1'b1;
        tick();
        tick();
        tests_run++;
        if (oREQ_LOCK !== 1'b0) begin
            tests_failed++; $display("FAIL reset_lock: got %b want 0", oREQ_LOCK);
        end
        tests_run++;
        if (oMEM_CMD_VALID !== 1'b0) begin
            tests_failed++; $display("FAIL reset_cmd_valid: got %b want 0", oMEM_CMD_VALID);
        end
        tests_run++;
        if (oRET_VALID !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ret_valid: got %b want 0", oRET_VALID);
        end
        tests_run++;
        if (oERR !== 1'b0) begin
            tests_failed++; $display("FAIL reset_err: got %b want 0", oERR);
        end
        tests_run++;
        if ({oRET_DATA, oMEM_CMD_ADDR, oMEM_CMD_BE, oMEM_CMD_WDATA, oMEM_CMD_WE} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: ret=%h addr=%h be=%h wdata=%h we=%b want all 0",
                     oRET_DATA, oMEM_CMD_ADDR, oMEM_CMD_BE, oMEM_CMD_WDATA, oMEM_CMD_WE);
        end
        iRESET_SYNC = 1'b0;
        tick();
    endtask

    task automatic test_read();
        iMEM_CMD_READY = 1'b1;
        iRET_BUSY      = 1'b0;
        set_req(1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tests_run++;
        if ({oMEM_CMD_VALID, oMEM_CMD_WE, oMEM_CMD_ADDR, oMEM_CMD_BE} !==
            {1'b1, 1'b0, 32'h0000_1000, 8'hF0}) begin
            tests_failed++;
            $display("FAIL read_cmd: got v=%b we=%b addr=%h be=%h want v=1 we=0 addr=00001000 be=f0",
                     oMEM_CMD_VALID, oMEM_CMD_WE, oMEM_CMD_ADDR, oMEM_CMD_BE);
        end
        tick();
        tests_run++;
        if (oMEM_CMD_VALID !== 1'b0) begin
            tests_failed++; $display("FAIL read_cmd_popped: got %b want 0", oMEM_CMD_VALID);
        end
        tick();
        tick();
        iMEM_RD_VALID = 1'b1;
        iMEM_RD_DATA  = 64'hA5A5_A5A5_A5A5_A5A5;
        tests_run++;
        if (oRET_VALID !== 1'b0) begin
            tests_failed++; $display("FAIL read_ret_early: got %b want 0", oRET_VALID);
        end
        tick();
        iMEM_RD_VALID = 1'b0;
        iMEM_RD_DATA  = 64'h0;
        tests_run++;
        if ({oRET_VALID, oRET_DATA} !== {1'b1, 64'hA5A5_A5A5_A5A5_A5A5}) begin
            tests_failed++;
            $display("FAIL read_ret: got v=%b data=%h want v=1 data=a5a5a5a5a5a5a5a5",
                     oRET_VALID, oRET_DATA);
        end
        tick();
        tests_run++;
        if ({oRET_VALID, oREQ_LOCK, oERR} !== 3'b000) begin
            tests_failed++;
            $display("FAIL read_done: got v=%b lock=%b err=%b want 0 0 0",
                     oRET_VALID, oREQ_LOCK, oERR);
        end
    endtask

    task automatic test_write();
        iMEM_CMD_READY = 1'b1;
        set_req(1'b1, 1'b1, 32'h0000_0010, 4'h3, 32'hDEAD_BEEF);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tests_run++;
        if ({oMEM_CMD_VALID, oMEM_CMD_WE, oMEM_CMD_ADDR, oMEM_CMD_BE, oMEM_CMD_WDATA} !==
            {1'b1, 1'b1, 32'h0000_0010, 8'h03, 64'hDEAD_BEEF_DEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL write_cmd: got v=%b we=%b addr=%h be=%h wdata=%h want 1 1 00000010 03 deadbeefdeadbeef",
                     oMEM_CMD_VALID, oMEM_CMD_WE, oMEM_CMD_ADDR, oMEM_CMD_BE, oMEM_CMD_WDATA);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({oMEM_CMD_VALID, oRET_VALID} !== 2'b00) begin
                tests_failed++;
                $display("FAIL write_no_ret[%0d]: got cmd_v=%b ret_v=%b want 0 0",
                         i, oMEM_CMD_VALID, oRET_VALID);
            end
        end
    endtask

    task automatic test_cmd_full();
        logic [31:0] d;
        iMEM_CMD_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 1'b1, 32'h0000_0100 + 32'(8 * i), 4'hF, 32'h1111_0000 + 32'(i));
            tests_run++;
            if (oREQ_LOCK !== (i == 4)) begin
                tests_failed++;
                $display("FAIL cmd_full_lock[%0d]: got %b want %b", i, oREQ_LOCK, (i == 4));
            end
            tick();
        end
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        iMEM_CMD_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 32'h1111_0000 + 32'(i);
            tests_run++;
            if ({oMEM_CMD_VALID, oMEM_CMD_ADDR, oMEM_CMD_BE, oMEM_CMD_WDATA, oREQ_LOCK} !==
                {1'b1, 32'h0000_0100 + 32'(8 * i), 8'h0F, d, d, (i == 0)}) begin
                tests_failed++;
                $display("FAIL cmd_drain[%0d]: got v=%b addr=%h be=%h wdata=%h lock=%b want 1 %h 0f %h%h %b",
                         i, oMEM_CMD_VALID, oMEM_CMD_ADDR, oMEM_CMD_BE, oMEM_CMD_WDATA,
                         oREQ_LOCK, 32'h0000_0100 + 32'(8 * i), d, d, (i == 0));
            end
            tick();
        end
        tests_run++;
        if (oMEM_CMD_VALID !== 1'b0) begin
            tests_failed++; $display("FAIL cmd_drain_empty: got %b want 0", oMEM_CMD_VALID);
        end
    endtask

    task automatic test_ret_full();
        iMEM_CMD_READY = 1'b1;
        iRET_BUSY      = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_req(1'b1, 1'b0, 32'h0000_0200 + 32'(8 * i), 4'hF, 32'h0);
            tests_run++;
            if (oREQ_LOCK !== (i == 8)) begin
                tests_failed++;
                $display("FAIL ret_full_lock[%0d]: got %b want %b", i, oREQ_LOCK, (i == 8));
            end
            tick();
        end
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            iMEM_RD_VALID = 1'b1;
            iMEM_RD_DATA  = 64'hC0DE_0000_0000_0000 + 64'(i);
            tick();
        end
        iMEM_RD_VALID = 1'b0;
        iMEM_RD_DATA  = 64'h0;
        tests_run++;
        if ({oRET_VALID, oREQ_LOCK, oERR} !== 3'b110) begin
            tests_failed++;
            $display("FAIL ret_full_held: got v=%b lock=%b err=%b want 1 1 0",
                     oRET_VALID, oREQ_LOCK, oERR);
        end
        iRET_BUSY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if ({oRET_VALID, oRET_DATA, oREQ_LOCK} !==
                {1'b1, 64'hC0DE_0000_0000_0000 + 64'(i), (i == 0)}) begin
                tests_failed++;
                $display("FAIL ret_drain[%0d]: got v=%b data=%h lock=%b want 1 %h %b", i,
                         oRET_VALID, oRET_DATA, oREQ_LOCK, 64'hC0DE_0000_0000_0000 + 64'(i),
                         (i == 0));
            end
            tick();
        end
        tests_run++;
        if ({oRET_VALID, oREQ_LOCK, oERR} !== 3'b000) begin
            tests_failed++;
            $display("FAIL ret_drain_done: got v=%b lock=%b err=%b want 0 0 0",
                     oRET_VALID, oREQ_LOCK, oERR);
        end
    endtask

    task automatic test_unexpected();
        iMEM_RD_VALID = 1'b1;
        iMEM_RD_DATA  = 64'h5555_6666_7777_8888;
        tick();
        iMEM_RD_VALID = 1'b0;
        iMEM_RD_DATA  = 64'h0;
        tests_run++;
        if ({oRET_VALID, oERR} !== 2'b01) begin
            tests_failed++;
            $display("FAIL unexpected_rsp: got v=%b err=%b want 0 1", oRET_VALID, oERR);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if ({oRET_VALID, oERR} !== 2'b01) begin
            tests_failed++;
            $display("FAIL unexpected_sticky: got v=%b err=%b want 0 1", oRET_VALID, oERR);
        end
    endtask

    task automatic test_mid_reset();
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        tests_run++;
        if (oERR !== 1'b0) begin
            tests_failed++; $display("FAIL err_cleared: got %b want 0", oERR);
        end
        iMEM_CMD_READY = 1'b1;
        iRET_BUSY      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 32'h0000_0300 + 32'(8 * i), 4'hF, 32'h0);
            tick();
        end
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        iMEM_CMD_READY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(1'b1, 1'b0, 32'h0000_0400 + 32'(8 * i), 4'hF, 32'h0);
            tick();
        end
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        iMEM_RD_VALID = 1'b1;
        iMEM_RD_DATA  = 64'h7777_0000_0000_0001;
        tick();
        iMEM_RD_VALID = 1'b0;
        iMEM_RD_DATA  = 64'h0;
        tests_run++;
        if ({oMEM_CMD_VALID, oMEM_CMD_ADDR, oRET_VALID, oREQ_LOCK} !==
            {1'b1, 32'h0000_0400, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got cv=%b addr=%h rv=%b lock=%b want 1 00000400 1 0",
                     oMEM_CMD_VALID, oMEM_CMD_ADDR, oRET_VALID, oREQ_LOCK);
        end
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        tests_run++;
        if ({oMEM_CMD_VALID, oRET_VALID, oREQ_LOCK, oERR} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_reset_ctrl: got cv=%b rv=%b lock=%b err=%b want 0 0 0 0",
                     oMEM_CMD_VALID, oRET_VALID, oREQ_LOCK, oERR);
        end
        tests_run++;
        if ({oRET_DATA, oMEM_CMD_ADDR, oMEM_CMD_BE, oMEM_CMD_WDATA, oMEM_CMD_WE} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_data: ret=%h addr=%h be=%h wdata=%h we=%b want all 0",
                     oRET_DATA, oMEM_CMD_ADDR, oMEM_CMD_BE, oMEM_CMD_WDATA, oMEM_CMD_WE);
        end
        // Fresh read after reset.
        iMEM_CMD_READY = 1'b1;
        iRET_BUSY      = 1'b0;
        set_req(1'b1, 1'b0, 32'h0000_2000, 4'h1, 32'h0);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tests_run++;
        if ({oMEM_CMD_VALID, oMEM_CMD_WE, oMEM_CMD_ADDR, oMEM_CMD_BE} !==
            {1'b1, 1'b0, 32'h0000_2000, 8'h01}) begin
            tests_failed++;
            $display("FAIL fresh_cmd: got v=%b we=%b addr=%h be=%h want 1 0 00002000 01",
                     oMEM_CMD_VALID, oMEM_CMD_WE, oMEM_CMD_ADDR, oMEM_CMD_BE);
        end
        tick();
        tick();
        iMEM_RD_VALID = 1'b1;
        iMEM_RD_DATA  = 64'h0123_4567_89AB_CDEF;
        tick();
        iMEM_RD_VALID = 1'b0;
        iMEM_RD_DATA  = 64'h0;
        tests_run++;
        if ({oRET_VALID, oRET_DATA, oERR} !== {1'b1, 64'h0123_4567_89AB_CDEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL fresh_ret: got v=%b data=%h err=%b want 1 0123456789abcdef 0",
                     oRET_VALID, oRET_DATA, oERR);
        end
        tick();
        // A late response for a pre-reset read is now unexpected.
        iMEM_RD_VALID = 1'b1;
        iMEM_RD_DATA  = 64'h7777_0000_0000_0002;
        tick();
        iMEM_RD_VALID = 1'b0;
        iMEM_RD_DATA  = 64'h0;
        tests_run++;
        if ({oRET_VALID, oERR} !== 2'b01) begin
            tests_failed++;
            $display("FAIL stale_rsp: got v=%b err=%b want 0 1", oRET_VALID, oERR);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRESET_SYNC    = 1'b1;
        iMEM_CMD_READY = 1'b0;
        iRET_BUSY      = 1'b0;
        iMEM_RD_VALID  = 1'b0;
        iMEM_RD_DATA   = 64'h0;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        test_reset();
        test_read();
        test_write();
        test_cmd_full();
        test_ret_full();
        test_unexpected();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
